atm_controller_multi: RTL and testbench
=======================================

Name: atm_controller_multi

Overview:
Parametrised next-generation ATM control FSM for the cajero datapath. It accepts a PIN of configurable length and checks it with a configurable attempt limit. It holds the account balance internally and executes deposits and withdrawals with overflow and underflow protection. It sits between the card/keypad front end (strobed inputs) and the dispenser/display logic (pulsed and level outputs).

Parameters:
PIN_DIGITS, 4, number of BCD digits in the PIN (1..8)
MONTO_W, 32, width of the transaction amount bus
BAL_W, 64, width of the internal balance register (must be >= MONTO_W)
MAX_INTENTOS, 3, failed PIN attempts before lockout (>= 2)
PIN_CORRECTO, 16'h7987, expected PIN, PIN_DIGITS*4 bits, first digit entered in the MSB nibble
BAL_INICIAL, 64'd50000, balance loaded at reset
TIMEOUT_CICLOS, 1000, inactivity limit (used only with ATM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tarjeta_recibida  input  1  level; card present
tipo_trans  input  1  0 = deposit, 1 = withdrawal; sampled with monto_stb
digito_stb  input  1  one-cycle strobe; digito is valid
digito  input  4  BCD PIN digit
monto_stb  input  1  one-cycle strobe; monto is valid
monto  input  MONTO_W  transaction amount
balance  output  BAL_W  current balance (registered)
balance_actualizado  output  1  one-cycle pulse; balance changed
entregar_dinero  output  1  one-cycle pulse; dispense approved
pin_incorrecto  output  1  one-cycle pulse; wrong PIN
advertencia  output  1  level; one attempt left
bloqueo  output  1  level; locked until rst
fondos_insuficientes  output  1  one-cycle pulse; withdrawal rejected

Behaviour:
- Reset (async, rst=1): state ESPERA_TARJETA, balance=BAL_INICIAL, intentos=0, digit counter=0, all pulse/level outputs 0.
- States:
  - ESPERA_TARJETA: on tarjeta_recibida=1 -> INGRESO_PIN; clear digit counter and PIN shift register.
  - INGRESO_PIN: each digito_stb shifts digito into the LSB nibble and increments the counter. When the counter reaches PIN_DIGITS -> VERIFICAR.
  - VERIFICAR (1 cycle): compare against PIN_CORRECTO.
    - Match: intentos=0, advertencia=0 -> ESPERA_MONTO.
    - Mismatch: pin_incorrecto pulses on the next cycle and intentos++.
      - If intentos==MAX_INTENTOS-1: advertencia=1, -> INGRESO_PIN.
      - If intentos==MAX_INTENTOS: bloqueo=1, -> BLOQUEO.
      - Otherwise -> INGRESO_PIN with the counter cleared.
  - ESPERA_MONTO: on monto_stb, latch monto and tipo_trans -> DEPOSITO or RETIRO.
  - DEPOSITO (1 cycle): balance += zero-extended monto, saturating at 2^BAL_W-1. balance_actualizado pulses even if saturated. -> FIN.
  - RETIRO (1 cycle):
    - If monto > balance: fondos_insuficientes pulses; balance unchanged.
    - Else: balance -= monto; balance_actualizado and entregar_dinero pulse together. monto==0 is treated as a valid withdrawal.
    - -> FIN.
  - FIN: wait for tarjeta_recibida=0 -> ESPERA_TARJETA.
  - BLOQUEO: absorbing; bloqueo=1 and all inputs ignored until rst.
- Latency: outputs are registered. Pulses assert exactly one cycle after the deciding state and last one cycle.
- Card removal: tarjeta_recibida=0 in INGRESO_PIN, VERIFICAR or ESPERA_MONTO -> ESPERA_TARJETA. Partial digits are discarded; intentos and advertencia are retained. A transaction already in DEPOSITO/RETIRO completes.
- Simultaneous strobes:
  - digito_stb is ignored outside INGRESO_PIN.
  - monto_stb is ignored outside ESPERA_MONTO.
  - If both are asserted together, only the one legal in the current state is used.
- Non-BCD digits (>9) are accepted and compared as raw nibbles, which guarantees a mismatch.
- intentos persists across card sessions. It clears only on a correct PIN or rst.

Optional Feature:
ATM_TIMEOUT_EN:
- Defined: a counter clears on any strobe or state change. If it reaches TIMEOUT_CICLOS in INGRESO_PIN or ESPERA_MONTO, the FSM goes to FIN; no pulses are emitted and intentos is unchanged.
- Undefined: no counter is synthesised and the FSM waits indefinitely. TIMEOUT_CICLOS is unused.

Decomposition:
- Package atm_pkg holds:
  - state enum (ESPERA_TARJETA, INGRESO_PIN, VERIFICAR, ESPERA_MONTO, DEPOSITO, RETIRO, FIN, BLOQUEO)
  - TIPO_DEPOSITO/TIPO_RETIRO constants
  - 4-bit digit typedef
- Sub-module atm_pin_collector: PIN_DIGITS shift register, digit counter, and a registered match flag and done flag. The top level keeps the FSM and balance arithmetic.

Test Plan:
- Correct PIN: rst, card in, digits 7,9,8,7, deposit 1000 -> balance_actualizado pulse, balance=51000, then card out -> ESPERA_TARJETA.
- Withdrawal: correct PIN, withdraw 50001 from 50000 -> fondos_insuficientes pulse, balance=50000. Second session withdraws 50000 -> entregar_dinero and balance_actualizado pulse, balance=0.
- Lockout: three wrong PINs (1,1,1,1) ->
  - pin_incorrecto pulses 3 times.
  - advertencia=1 after the 2nd pulse.
  - bloqueo=1 after the 3rd pulse.
  - A correct PIN afterwards is ignored until rst.
- Attempts persistence: two wrong PINs, card removed mid-digit (2 digits entered), card reinserted. Correct PIN -> advertencia clears. Third wrong PIN in a later session -> no bloqueo.
- Saturation: BAL_INICIAL=2^64-10, deposit 100 -> balance=2^64-1, balance_actualizado pulses.
- ATM_TIMEOUT_EN with TIMEOUT_CICLOS=20: card in, 2 digits, idle 20 cycles -> FIN, no pin_incorrecto, intentos unchanged.

Source files
------------

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encoding, transaction type codes and digit type for the ATM controller
package atm_pkg;

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    INGRESO_PIN,
    VERIFICAR,
    ESPERA_MONTO,
    DEPOSITO,
    RETIRO,
    FIN,
    BLOQUEO
  } estado_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  typedef logic [3:0] digito_t;

endpackage

// File: rtl/atm_pin_collector.sv
// rtl/atm_pin_collector.sv - PIN shift register and digit counter with registered done/match flags
module atm_pin_collector
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter logic [PIN_DIGITS*4-1:0] PIN_CORRECTO = 16'h7987
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic [3:0] digito,
  output logic       done,
  output logic       match
);

  localparam int PW = PIN_DIGITS * 4;
  localparam logic [3:0] N_DIG = 4'(PIN_DIGITS);

  logic [PW-1:0] pin_q, pin_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  digito_t       dig;

  assign dig = digito;

  always_comb begin
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    match_d = match_q;
    if (clear) begin
      pin_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      match_d = 1'b0;
    end else if (shift_en && !done_q) begin
      // Digits past the last one are dropped until the FSM consumes the result
      pin_d   = (pin_q << 4) | PW'(dig);
      cnt_d   = cnt_q + 4'd1;
      done_d  = (cnt_d == N_DIG);
      match_d = (pin_d == PIN_CORRECTO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign done  = done_q;
  assign match = match_q;

endmodule

// File: rtl/atm_controller_multi.sv
// rtl/atm_controller_multi.sv - ATM control FSM with PIN check, lockout and saturating balance
// Optional inactivity timeout in INGRESO_PIN/ESPERA_MONTO enabled by defining ATM_TIMEOUT_EN.
module atm_controller_multi
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int MONTO_W = 32,
  parameter int BAL_W = 64,
  parameter int MAX_INTENTOS = 3,
  parameter logic [PIN_DIGITS*4-1:0] PIN_CORRECTO = 16'h7987,
  parameter logic [BAL_W-1:0] BAL_INICIAL = 64'd50000,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tarjeta_recibida,
  input  logic               tipo_trans,
  input  logic               digito_stb,
  input  logic [3:0]         digito,
  input  logic               monto_stb,
  input  logic [MONTO_W-1:0] monto,
  output logic [BAL_W-1:0]   balance,
  output logic               balance_actualizado,
  output logic               entregar_dinero,
  output logic               pin_incorrecto,
  output logic               advertencia,
  output logic               bloqueo,
  output logic               fondos_insuficientes
);

  localparam int SW = BAL_W + 1;
  localparam logic [7:0] INT_MAX   = 8'(MAX_INTENTOS);
  localparam logic [7:0] INT_AVISO = 8'(MAX_INTENTOS - 1);

  estado_t            state_q, state_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic [7:0]         intentos_q, intentos_d, intentos_inc;
  logic               adv_q, adv_d, blq_q, blq_d;
  logic               bal_act_q, bal_act_d, entregar_q, entregar_d;
  logic               pin_inc_q, pin_inc_d, fondos_q, fondos_d;
  logic               pin_clear, pin_shift, pin_done, pin_match;
  logic [BAL_W-1:0]   monto_ext;
  logic [BAL_W:0]     suma;

  assign pin_clear = (state_q != INGRESO_PIN);
  assign pin_shift = (state_q == INGRESO_PIN) && tarjeta_recibida && digito_stb;

  atm_pin_collector #(
    .PIN_DIGITS  (PIN_DIGITS),
    .PIN_CORRECTO(PIN_CORRECTO)
  ) u_pin (
    .clk     (clk),
    .rst     (rst),
    .clear   (pin_clear),
    .shift_en(pin_shift),
    .digito  (digito),
    .done    (pin_done),
    .match   (pin_match)
  );

  assign monto_ext    = BAL_W'(monto_q);
  assign suma         = SW'(bal_q) + SW'(monto_ext);
  assign intentos_inc = intentos_q + 8'd1;

`ifdef ATM_TIMEOUT_EN
  localparam logic [31:0] TMO_N = 32'(TIMEOUT_CICLOS);
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CICLOS != 0);
`endif

  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    monto_d    = monto_q;
    intentos_d = intentos_q;
    adv_d      = adv_q;
    blq_d      = blq_q;
    bal_act_d  = 1'b0;
    entregar_d = 1'b0;
    pin_inc_d  = 1'b0;
    fondos_d   = 1'b0;
    case (state_q)
      ESPERA_TARJETA: if (tarjeta_recibida) state_d = INGRESO_PIN;
      INGRESO_PIN: begin
        if (!tarjeta_recibida) state_d = ESPERA_TARJETA;
        else if (pin_done)     state_d = VERIFICAR;
      end
      VERIFICAR: begin
        if (!tarjeta_recibida) begin
          state_d = ESPERA_TARJETA;
        end else if (pin_match) begin
          intentos_d = '0;
          adv_d      = 1'b0;
          state_d    = ESPERA_MONTO;
        end else begin
          pin_inc_d  = 1'b1;
          intentos_d = intentos_inc;
          if (intentos_inc == INT_MAX) begin
            blq_d   = 1'b1;
            state_d = BLOQUEO;
          end else begin
            if (intentos_inc == INT_AVISO) adv_d = 1'b1;
            state_d = INGRESO_PIN;
          end
        end
      end
      ESPERA_MONTO: begin
        if (!tarjeta_recibida) begin
          state_d = ESPERA_TARJETA;
        end else if (monto_stb) begin
          monto_d = monto;
          state_d = (tipo_trans == TIPO_RETIRO) ? RETIRO : DEPOSITO;
        end
      end
      DEPOSITO: begin
        bal_d     = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
        bal_act_d = 1'b1;
        state_d   = FIN;
      end
      RETIRO: begin
        if (monto_ext > bal_q) begin
          fondos_d = 1'b1;
        end else begin
          bal_d      = bal_q - monto_ext;
          bal_act_d  = 1'b1;
          entregar_d = 1'b1;
        end
        state_d = FIN;
      end
      FIN:     if (!tarjeta_recibida) state_d = ESPERA_TARJETA;
      BLOQUEO: blq_d = 1'b1;
      default: state_d = ESPERA_TARJETA;
    endcase
`ifdef ATM_TIMEOUT_EN
    if ((state_q == INGRESO_PIN || state_q == ESPERA_MONTO) && tarjeta_recibida &&
        !digito_stb && !monto_stb && (tmo_q == TMO_N))
      state_d = FIN;
    tmo_d = tmo_q;
    if ((state_d != state_q) || digito_stb || monto_stb) tmo_d = '0;
    else if (tmo_q != TMO_N)                             tmo_d = tmo_q + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ESPERA_TARJETA;
      bal_q      <= BAL_INICIAL;
      monto_q    <= '0;
      intentos_q <= '0;
      adv_q      <= 1'b0;
      blq_q      <= 1'b0;
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      fondos_q   <= 1'b0;
`ifdef ATM_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bal_q      <= bal_d;
      monto_q    <= monto_d;
      intentos_q <= intentos_d;
      adv_q      <= adv_d;
      blq_q      <= blq_d;
      bal_act_q  <= bal_act_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      fondos_q   <= fondos_d;
`ifdef ATM_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign balance              = bal_q;
  assign balance_actualizado  = bal_act_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = blq_q;
  assign fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_atm_controller_multi.sv
// tb/tb_atm_controller_multi.sv - directed bench with transaction-level ATM model and pulse scoreboard
module tb_atm_controller_multi;

  localparam logic [63:0] SAT_INI = 64'hFFFF_FFFF_FFFF_FFF6;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int MAX_INT = 3;

  logic clk = 1'b0, rst = 1'b1, rst_sat = 1'b1;
  logic tarjeta = 1'b0, tipo = 1'b0, dstb = 1'b0, mstb = 1'b0;
  logic [3:0] dig = 4'd0;
  logic [31:0] monto = 32'd0;
  logic [63:0] balance, s_balance;
  logic ba, ed, pi, adv, blq, fi;
  logic s_ba, s_ed, s_pi, s_adv, s_blq, s_fi;

  always #5 clk = ~clk;

  atm_controller_multi #(.TIMEOUT_CICLOS(20)) dut (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta), .tipo_trans(tipo),
    .digito_stb(dstb), .digito(dig), .monto_stb(mstb), .monto(monto),
    .balance(balance), .balance_actualizado(ba), .entregar_dinero(ed),
    .pin_incorrecto(pi), .advertencia(adv), .bloqueo(blq), .fondos_insuficientes(fi)
  );

  atm_controller_multi #(.BAL_INICIAL(SAT_INI), .TIMEOUT_CICLOS(20)) u_sat (
    .clk(clk), .rst(rst_sat), .tarjeta_recibida(tarjeta), .tipo_trans(tipo),
    .digito_stb(dstb), .digito(dig), .monto_stb(mstb), .monto(monto),
    .balance(s_balance), .balance_actualizado(s_ba), .entregar_dinero(s_ed),
    .pin_incorrecto(s_pi), .advertencia(s_adv), .bloqueo(s_blq), .fondos_insuficientes(s_fi)
  );

  typedef struct {
    logic ba, ed, pi, fi, adv_care, adv, blq;
    logic [63:0] bal;
  } ev_t;

  ev_t exp_q[$];
  ev_t cur;
  int vectors = 0, miscompares = 0, sat_pulses = 0;
  logic [63:0] m_bal;
  int m_int;
  logic m_adv, m_blq, m_ready;

  task automatic model_reset();
    m_bal = 64'd50000; m_int = 0; m_adv = 1'b0; m_blq = 1'b0; m_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_ev(input logic eba, eed, epi, efi, care);
    ev_t e;
    e.ba = eba; e.ed = eed; e.pi = epi; e.fi = efi; e.adv_care = care;
    e.adv = m_adv; e.blq = m_blq; e.bal = m_bal;
    exp_q.push_back(e);
  endtask

  task automatic model_pin(input logic [15:0] p);
    if (m_blq) return;
    if (p == 16'h7987) begin
      m_int = 0; m_adv = 1'b0; m_ready = 1'b1;
    end else begin
      m_int++;
      if (m_int >= MAX_INT) begin
        m_blq = 1'b1;
        push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        if (m_int == MAX_INT - 1) m_adv = 1'b1;
        push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic model_trans(input logic t, input logic [31:0] amt);
    logic [64:0] s;
    if (m_blq || !m_ready) return;
    m_ready = 1'b0;
    if (!t) begin
      s = {1'b0, m_bal} + {33'd0, amt};
      m_bal = s[64] ? ALL_ONES : s[63:0];
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end else if ({32'd0, amt} > m_bal) begin
      push_ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      m_bal = m_bal - {32'd0, amt};
      push_ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic card(input logic v);
    tarjeta = v;
    if (!v) m_ready = 1'b0;
    step(2);
  endtask

  task automatic drive_digit(input logic [3:0] d);
    dig = d; dstb = 1'b1; step(1); dstb = 1'b0; step(1);
  endtask

  task automatic drive_pin(input logic [15:0] p);
    model_pin(p);
    for (int i = 0; i < 4; i++) drive_digit(p[15-4*i -: 4]);
    step(4);
  endtask

  task automatic drive_monto(input logic t, input logic [31:0] amt);
    model_trans(t, amt);
    tipo = t; monto = amt; mstb = 1'b1; step(1); mstb = 1'b0; step(4);
  endtask

  task automatic drive_both(input logic [3:0] d, input logic t, input logic [31:0] amt);
    dig = d; dstb = 1'b1; tipo = t; monto = amt; mstb = 1'b1;
    step(1); dstb = 1'b0; mstb = 1'b0; step(4);
  endtask

  task automatic checkpoint(input string name);
    chk({name, "_balance"}, balance, m_bal);
    chk({name, "_advertencia"}, 64'(adv), 64'(m_adv));
    chk({name, "_bloqueo"}, 64'(blq), 64'(m_blq));
    chk({name, "_pending_events"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0; model_reset(); step(1);
  endtask

  // Every cycle carrying a pulse must match the next expected event exactly
  always @(negedge clk) begin
    if (!rst && (ba || ed || pi || fi)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got ba=%0b ed=%0b pi=%0b fi=%0b bal=%0d required no pulse",
                 ba, ed, pi, fi, balance);
      end else begin
        cur = exp_q.pop_front();
        if (ba !== cur.ba || ed !== cur.ed || pi !== cur.pi || fi !== cur.fi ||
            balance !== cur.bal || blq !== cur.blq || (cur.adv_care && adv !== cur.adv)) begin
          miscompares++;
          $display("FAIL event: got ba=%0b ed=%0b pi=%0b fi=%0b bal=%0d adv=%0b blq=%0b required ba=%0b ed=%0b pi=%0b fi=%0b bal=%0d adv=%0b blq=%0b",
                   ba, ed, pi, fi, balance, adv, blq,
                   cur.ba, cur.ed, cur.pi, cur.fi, cur.bal, cur.adv, cur.blq);
        end
      end
    end
  end

  always @(negedge clk) if (!rst_sat && s_ba) sat_pulses++;

  initial begin
    model_reset();
    do_reset();
    chk("reset_balance", balance, 64'd50000);
    chk("reset_advertencia", 64'(adv), 64'd0);
    chk("reset_bloqueo", 64'(blq), 64'd0);
    chk("reset_pulses", 64'({ba, ed, pi, fi}), 64'd0);

    // Correct PIN, last digit and then deposit issued alongside the other strobe
    card(1'b1);
    drive_digit(4'd7); drive_digit(4'd9); drive_digit(4'd8);
    model_pin(16'h7987);
    drive_both(4'd7, 1'b1, 32'd5);
    model_trans(1'b0, 32'd1000);
    drive_both(4'd3, 1'b0, 32'd1000);
    chk("deposit_1000", balance, 64'd51000);
    card(1'b0);
    checkpoint("after_deposit");

    do_reset();
    card(1'b1); drive_pin(16'h7987); drive_monto(1'b1, 32'd50001);
    chk("overdraw_balance", balance, 64'd50000);
    card(1'b0);
    card(1'b1); drive_pin(16'h7987); drive_monto(1'b1, 32'd50000);
    chk("withdraw_all", balance, 64'd0);
    card(1'b0);
    checkpoint("after_withdraw");

    rst_sat = 1'b0; step(1);
    card(1'b1); drive_pin(16'h7987); drive_monto(1'b0, 32'd100);
    chk("main_deposit_100", balance, 64'd100);
    chk("sat_balance", s_balance, ALL_ONES);
    chk("sat_pulse_count", 64'(sat_pulses), 64'd1);
    card(1'b0);
    card(1'b1); drive_pin(16'h7987); drive_monto(1'b1, 32'd0);
    card(1'b0);
    checkpoint("zero_withdraw");

    card(1'b1); drive_pin(16'h1111); drive_pin(16'h1111);
    chk("warn_after_two", 64'(adv), 64'd1);
    card(1'b0);
    card(1'b1); drive_digit(4'd7); drive_digit(4'd9); card(1'b0);
    card(1'b1); drive_pin(16'h7987);
    chk("warn_cleared", 64'(adv), 64'd0);
    card(1'b0);
    card(1'b1); drive_pin(16'hF987);
    chk("no_lock_after_clear", 64'(blq), 64'd0);
    card(1'b0);
    checkpoint("persistence");

`ifdef ATM_TIMEOUT_EN
    card(1'b1); drive_digit(4'd1); drive_digit(4'd1); step(25);
    for (int i = 0; i < 4; i++) drive_digit(4'd1);
    step(4);
    drive_monto(1'b0, 32'd7);
    card(1'b0);
    checkpoint("timeout");
    card(1'b1); drive_pin(16'h1111);
    chk("timeout_kept_intentos", 64'(adv), 64'd1);
    card(1'b0);
`endif

    do_reset();
    card(1'b1);
    drive_pin(16'h1111); drive_pin(16'h1111); drive_pin(16'h1111);
    chk("locked", 64'(blq), 64'd1);
    drive_pin(16'h7987); drive_monto(1'b0, 32'd500);
    card(1'b0);
    checkpoint("lockout");
    do_reset();
    chk("unlock_by_rst", 64'(blq), 64'd0);
    checkpoint("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
